// File: rtl/led_show_sched_if.sv
// Request/pattern/duration bundle between LED effect generators and the scheduler,
// plus the grant/done handshake and the scheduled LED drive coming back.
interface led_show_sched_if #(
  parameter int DUR_W = 4
);
  logic [2:0]       req;
  logic [3:0]       pat0;
  logic [3:0]       pat1;
  logic [3:0]       pat2;
  logic [DUR_W-1:0] dur0;
  logic [DUR_W-1:0] dur1;
  logic [DUR_W-1:0] dur2;
  logic [2:0]       gnt;
  logic [2:0]       done;
  logic             busy;
  logic [3:0]       led;

  modport master (
    output req, pat0, pat1, pat2, dur0, dur1, dur2,
    input  gnt, done, busy, led
  );

  modport slave (
    input  req, pat0, pat1, pat2, dur0, dur1, dur2,
    output gnt, done, busy, led
  );
endinterface

// File: rtl/led_show_sched.sv
// Round-robin time-sharing of the 4-LED bank between three requesters:
// each grant shows a latched pattern for dur ticks, then one all-off tick.
module led_show_sched #(
  parameter int TICK_CNT = 25000000,
  parameter int DUR_W    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  led_show_sched_if.slave bus
);
  localparam int            PW        = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_CNT - 1);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [DUR_W-1:0] ticks_q, ticks_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       owner_q, owner_d;
  logic [2:0]       gnt_q, gnt_d;
  logic [2:0]       done_q, done_d;
  logic             busy_q, busy_d;
  logic [3:0]       led_q, led_d;

  logic             tick;
  logic             win_vld;
  logic [1:0]       win_idx;
  logic [1:0]       cand;
  logic [3:0]       pat_arr [3];
  logic [DUR_W-1:0] dur_arr [3];

  assign pat_arr[0] = bus.pat0;
  assign pat_arr[1] = bus.pat1;
  assign pat_arr[2] = bus.pat2;
  assign dur_arr[0] = bus.dur0;
  assign dur_arr[1] = bus.dur1;
  assign dur_arr[2] = bus.dur2;

  assign tick = (presc_q == PRESC_MAX);

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    win_vld = 1'b0;
    win_idx = 2'd0;
    cand    = rr_next(last_q);
    for (int k = 0; k < 3; k++) begin
      if (!win_vld && bus.req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
      cand = rr_next(cand);
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    ticks_d = ticks_q;
    dur_d   = dur_q;
    last_d  = last_q;
    owner_d = owner_q;
    gnt_d   = 3'b000;
    done_d  = 3'b000;
    led_d   = led_q;

    case (state_q)
      IDLE: begin
        led_d = 4'hF;
        if (win_vld) begin
          state_d = SHOW;
          gnt_d   = 3'b001 << win_idx;
          led_d   = pat_arr[win_idx];
          last_d  = win_idx;
          owner_d = win_idx;
          // A zero duration still shows for one tick.
          dur_d   = (dur_arr[win_idx] == '0) ? DUR_W'(1) : dur_arr[win_idx];
          presc_d = '0;
          ticks_d = '0;
        end
      end
      SHOW: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          if (ticks_q == dur_q - DUR_W'(1)) begin
            state_d = GAP;
            led_d   = 4'hF;
            done_d  = 3'b001 << owner_q;
            ticks_d = '0;
          end else begin
            ticks_d = ticks_q + DUR_W'(1);
          end
        end
      end
      GAP: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        led_d   = 4'hF;
        if (tick) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        led_d   = 4'hF;
        presc_d = '0;
        ticks_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      ticks_q <= '0;
      dur_q   <= '0;
      last_q  <= 2'd2;
      owner_q <= 2'd0;
      gnt_q   <= 3'b000;
      done_q  <= 3'b000;
      busy_q  <= 1'b0;
      led_q   <= 4'hF;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ticks_q <= ticks_d;
      dur_q   <= dur_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.led  = led_q;
endmodule
